// File: rtl/mul_iter_unit.sv
// mul_iter_unit: iterative RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU), RADIX_BITS multiplier bits per RUN cycle.
// Optional MUL_EARLY_OUT_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module mul_iter_unit #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N + 1);
  localparam int W2 = 2 * WIDTH;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [W2-1:0]    acc, mcand, acc_nxt, res;
  logic [WIDTH-1:0] mb, mb_nxt, mag_a, mag_b;
  logic             neg, a_neg, b_neg, last;
  assign in_ready = state == IDLE;
  // mcand and mb shift each step, so the current digit is always mb's low RADIX_BITS
  always_comb begin
    a_neg   = (op == 2'b01 || op == 2'b10) && a[WIDTH-1];
    b_neg   = op == 2'b01 && b[WIDTH-1];
    mag_a   = a_neg ? -a : a;
    mag_b   = b_neg ? -b : b;
    mb_nxt  = mb >> RADIX_BITS;
    acc_nxt = acc + mcand * W2'(mb[RADIX_BITS-1:0]);
    res     = neg ? -acc : acc;
`ifdef MUL_EARLY_OUT_EN
    last    = cnt == CW'(N - 1) || mb_nxt == '0;
`else
    last    = cnt == CW'(N - 1);
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mb        <= '0;
      neg       <= 1'b0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state <= RUN;
          mcand <= W2'(mag_a);
          mb    <= mag_b;
          neg   <= a_neg ^ b_neg;
          acc   <= '0;
          cnt   <= '0;
        end
        RUN: begin
          acc   <= acc_nxt;
          mcand <= mcand << RADIX_BITS;
          mb    <= mb_nxt;
          cnt   <= cnt + CW'(1);
          state <= last ? FIX : RUN;
        end
        FIX: begin
          hi        <= res[W2-1:WIDTH];
          lo        <= res[WIDTH-1:0];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        default: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule
